demux_1xn_seq: RTL and testbench

//   Registered 1-to-N demultiplexer; inverse of the N-to-1 selector.

---
 rtl/demux_1xn_seq.sv | 129 ++++++++++++
 tb/tb_demux_1xn_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1xn_seq.sv
// ----------------------------------------------------------------------------
// demux_1xn_seq
//   Registered 1-to-N demultiplexer. A single data bit is routed into one bit of
//   a held SIZE-bit output word. Two write modes:
//     manual    (auto = 0): the bit addressed by demux_1xn_sel is written
//     auto-scan (auto = 1): an internal pointer fills bits 0..SIZE-1 in order
//                           and pulses demux_1xn_frame_done on the last bit
//   Dropping auto mid-frame aborts the frame (pointer returns to 0).
//
// Optional feature (compile-time macro DEMUX_1XN_SHADOW_EN):
//   Double-buffered output. Auto-scan bits collect in a shadow register and
//   the whole word is copied to the output on the frame-completing edge, so a
//   partial, aborted or reset frame never reaches the output.
//
// Ports
//   demux_1xn_clk         in   1      clock, rising edge
//   demux_1xn_rst         in   1      synchronous active-high reset
//   demux_1xn_in          in   1      data bit to route
//   demux_1xn_sel         in   SEL_W  manual-mode destination index
//   demux_1xn_we          in   1      write strobe, one bit per cycle
//   demux_1xn_auto        in   1      1 = auto-scan, 0 = manual
//   demux_1xn_out         out  SIZE   registered output word
//   demux_1xn_ptr         out  SEL_W  next auto-scan bit to be written
//   demux_1xn_frame_done  out  1      one-cycle pulse when a frame completes
// ----------------------------------------------------------------------------
module demux_1xn_seq #(
  parameter int SIZE = 8,
  localparam int SEL_W = $clog2(SIZE)
) (
  input  logic             demux_1xn_clk,
  input  logic             demux_1xn_rst,
  input  logic             demux_1xn_in,
  input  logic [SEL_W-1:0] demux_1xn_sel,
  input  logic             demux_1xn_we,
  input  logic             demux_1xn_auto,
  output logic [SIZE-1:0]  demux_1xn_out,
  output logic [SEL_W-1:0] demux_1xn_ptr,
  output logic             demux_1xn_frame_done
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StFill = 1'b1;

  localparam logic [SEL_W-1:0] LastPtr = SEL_W'(SIZE - 1);
  localparam logic [SEL_W:0]   SizeW   = (SEL_W + 1)'(SIZE);

  logic [SIZE-1:0]  out_q, out_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [0:0]       state_q, state_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] wr_idx;
  logic             sel_ok;
`ifdef DEMUX_1XN_SHADOW_EN
  logic [SIZE-1:0]  shadow_q, shadow_d;
`endif

  // Out-of-range manual selects (possible when SIZE is not a power of 2) are dropped.
  assign sel_ok = ({1'b0, demux_1xn_sel} < SizeW);

  // A frame always starts at bit 0; in FILL the pointer names the next bit.
  assign wr_idx = (state_q == StIdle) ? '0 : ptr_q;

  always_comb begin
    out_d    = out_q;
    ptr_d    = ptr_q;
    state_d  = state_q;
    done_d   = 1'b0;
`ifdef DEMUX_1XN_SHADOW_EN
    shadow_d = shadow_q;
`endif
    if (demux_1xn_auto) begin
      // Auto-scan: sel is ignored; !we is a gap that holds pointer and state.
      if (demux_1xn_we) begin
`ifdef DEMUX_1XN_SHADOW_EN
        shadow_d[wr_idx] = demux_1xn_in;
`else
        out_d[wr_idx] = demux_1xn_in;
`endif
        if (wr_idx == LastPtr) begin
          ptr_d   = '0;
          state_d = StIdle;
          done_d  = 1'b1;
`ifdef DEMUX_1XN_SHADOW_EN
          // Publish the completed word, final bit included, on the wrap edge.
          out_d = shadow_d;
`endif
        end else begin
          ptr_d   = wr_idx + SEL_W'(1);
          state_d = StFill;
        end
      end
    end else begin
      // Manual mode; also aborts any frame in progress without a done pulse.
      ptr_d   = '0;
      state_d = StIdle;
      if (demux_1xn_we && sel_ok) begin
        out_d[demux_1xn_sel] = demux_1xn_in;
`ifdef DEMUX_1XN_SHADOW_EN
        shadow_d[demux_1xn_sel] = demux_1xn_in;
`endif
      end
    end
  end

  always_ff @(posedge demux_1xn_clk) begin
    if (demux_1xn_rst) begin
      out_q    <= '0;
      ptr_q    <= '0;
      state_q  <= StIdle;
      done_q   <= 1'b0;
`ifdef DEMUX_1XN_SHADOW_EN
      shadow_q <= '0;
`endif
    end else begin
      out_q    <= out_d;
      ptr_q    <= ptr_d;
      state_q  <= state_d;
      done_q   <= done_d;
`ifdef DEMUX_1XN_SHADOW_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign demux_1xn_out        = out_q;
  assign demux_1xn_ptr        = ptr_q;
  assign demux_1xn_frame_done = done_q;

endmodule

// File: tb/tb_demux_1xn_seq.sv
// Bench for demux_1xn_seq: drives a SIZE=8 and a SIZE=6 instance with the same
// inputs, checks directed scenarios against constants and a random run against
// a word/position reference model.
module tb_demux_1xn_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic [2:0] sel = '0;
  logic       we = 1'b0;
  logic       auto_en = 1'b0;

  logic [7:0] out8;
  logic [2:0] ptr8;
  logic       done8;
  logic [5:0] out6;
  logic [2:0] ptr6;
  logic       done6;

  int total = 0;
  int bad = 0;

`ifdef DEMUX_1XN_SHADOW_EN
  localparam bit Shadow = 1'b1;
`else
  localparam bit Shadow = 1'b0;
`endif

  // Reference state: [0] = SIZE 8, [1] = SIZE 6.
  int unsigned m_out[2];
  int unsigned m_sh[2];
  int unsigned m_pos[2];
  bit          m_done[2];

  always #5 clk = ~clk;

  demux_1xn_seq #(.SIZE(8)) u_dut8 (
    .demux_1xn_clk       (clk),
    .demux_1xn_rst       (rst),
    .demux_1xn_in        (din),
    .demux_1xn_sel       (sel),
    .demux_1xn_we        (we),
    .demux_1xn_auto      (auto_en),
    .demux_1xn_out       (out8),
    .demux_1xn_ptr       (ptr8),
    .demux_1xn_frame_done(done8)
  );

  demux_1xn_seq #(.SIZE(6)) u_dut6 (
    .demux_1xn_clk       (clk),
    .demux_1xn_rst       (rst),
    .demux_1xn_in        (din),
    .demux_1xn_sel       (sel),
    .demux_1xn_we        (we),
    .demux_1xn_auto      (auto_en),
    .demux_1xn_out       (out6),
    .demux_1xn_ptr       (ptr6),
    .demux_1xn_frame_done(done6)
  );

  function automatic int unsigned put_bit(int unsigned w, int unsigned p, logic b);
    return (w & ~(32'd1 << p)) | (int'(b) << p);
  endfunction

  // One clock of the word-level behaviour for instance i.
  task automatic model_step(input int i);
    int unsigned size;
    size = (i == 0) ? 8 : 6;
    m_done[i] = 1'b0;
    if (rst) begin
      m_out[i] = 0; m_sh[i] = 0; m_pos[i] = 0;
    end else if (auto_en) begin
      if (we) begin
        if (Shadow) m_sh[i] = put_bit(m_sh[i], m_pos[i], din);
        else        m_out[i] = put_bit(m_out[i], m_pos[i], din);
        if (m_pos[i] + 1 == size) begin
          m_pos[i] = 0;
          m_done[i] = 1'b1;
          if (Shadow) m_out[i] = m_sh[i];
        end else begin
          m_pos[i] = m_pos[i] + 1;
        end
      end
    end else begin
      m_pos[i] = 0;
      if (we && sel < size) begin
        m_out[i] = put_bit(m_out[i], sel, din);
        m_sh[i]  = put_bit(m_sh[i], sel, din);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; auto_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; din = 1'b1; auto_en = 1'b0; sel = 3'd3;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (out8 !== 8'h00 || ptr8 !== 3'd0 || done8 !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc%0d got out=%h ptr=%0d done=%b want out=00 ptr=0 done=0",
                 k, out8, ptr8, done8);
      end
    end
    rst = 1'b0; we = 1'b0;
  endtask

  task automatic test_manual();
    logic [7:0] exp [3];
    logic [2:0] sels [3];
    logic       bits [3];
    exp = '{8'h20, 8'h00, 8'h04};
    sels = '{3'd5, 3'd5, 3'd2};
    bits = '{1'b1, 1'b0, 1'b1};
    auto_en = 1'b0; we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = sels[k]; din = bits[k];
      tick();
      total++;
      if (out8 !== exp[k]) begin
        bad++;
        $display("FAIL manual step%0d got=%h want=%h", k, out8, exp[k]);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_auto_frame(input bit with_gap);
    logic [7:0] data;
    data = 8'h4D;
    auto_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      we = 1'b1; din = data[k];
      tick();
      total++;
      if (done8 !== (k == 7) || ptr8 !== 3'((k + 1) % 8)) begin
        bad++;
        $display("FAIL auto_frame gap=%0d bit%0d got done=%b ptr=%0d want done=%b ptr=%0d",
                 with_gap, k, done8, ptr8, (k == 7), (k + 1) % 8);
      end
      if (with_gap && k == 3) begin
        we = 1'b0; din = 1'b1;
        for (int g = 0; g < 3; g++) begin
          tick();
          total++;
          if (done8 !== 1'b0 || ptr8 !== 3'd4) begin
            bad++;
            $display("FAIL auto_gap cyc%0d got done=%b ptr=%0d want done=0 ptr=4",
                     g, done8, ptr8);
          end
        end
      end
    end
    total++;
    if (out8 !== 8'h4D) begin
      bad++;
      $display("FAIL auto_frame gap=%0d out got=%h want=4d", with_gap, out8);
    end
    we = 1'b0;
    tick();
    total++;
    if (done8 !== 1'b0) begin
      bad++;
      $display("FAIL auto_frame gap=%0d pulse_width got done=%b want 0", with_gap, done8);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] exp_out;
    exp_out = Shadow ? 8'h00 : 8'h07;
    do_reset();
    auto_en = 1'b1; we = 1'b1; din = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        auto_en = 1'b0; we = 1'b0;
      end
      tick();
      total++;
      if (done8 !== 1'b0) begin
        bad++;
        $display("FAIL abort cyc%0d done got=%b want 0", k, done8);
      end
    end
    total++;
    if (ptr8 !== 3'd0 || out8 !== exp_out) begin
      bad++;
      $display("FAIL abort end got ptr=%0d out=%h want ptr=0 out=%h", ptr8, out8, exp_out);
    end
  endtask

  task automatic test_size6();
    do_reset();
    auto_en = 1'b0; we = 1'b1; sel = 3'd7; din = 1'b1;
    tick();
    total++;
    if (out6 !== 6'h00) begin
      bad++;
      $display("FAIL size6 sel_oob got=%h want=00", out6);
    end
    auto_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (done6 !== (k == 5) || ptr6 !== 3'((k + 1) % 6)) begin
        bad++;
        $display("FAIL size6 bit%0d got done=%b ptr=%0d want done=%b ptr=%0d",
                 k, done6, ptr6, (k == 5), (k + 1) % 6);
      end
    end
    total++;
    if (out6 !== 6'h3F) begin
      bad++;
      $display("FAIL size6 out got=%h want=3f", out6);
    end
    we = 1'b0;
    tick();
    total++;
    if (done6 !== 1'b0) begin
      bad++;
      $display("FAIL size6 pulse_width got done=%b want 0", done6);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] data;
    do_reset();
    auto_en = 1'b1; we = 1'b1; din = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out8 !== 8'h00 || ptr8 !== 3'd0 || done8 !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got out=%h ptr=%0d done=%b want out=00 ptr=0 done=0",
               out8, ptr8, done8);
    end
    data = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      din = data[k];
      tick();
      total++;
      if (done8 !== (k == 7)) begin
        bad++;
        $display("FAIL rst_mid refill bit%0d done got=%b want=%b", k, done8, (k == 7));
      end
    end
    total++;
    if (out8 !== data) begin
      bad++;
      $display("FAIL rst_mid refill out got=%h want=%h", out8, data);
    end
    we = 1'b0; auto_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] data;
    do_reset();
    data = 16'($urandom);
    auto_en = 1'b1; we = 1'b1;
    for (int k = 0; k < 16; k++) begin
      din = data[k];
      tick();
      total++;
      if (done8 !== (k == 7 || k == 15)) begin
        bad++;
        $display("FAIL b2b edge%0d done got=%b want=%b", k, done8, (k == 7 || k == 15));
      end
    end
    total++;
    if (out8 !== data[15:8]) begin
      bad++;
      $display("FAIL b2b out got=%h want=%h", out8, data[15:8]);
    end
    we = 1'b0; auto_en = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(39) == 0);
      auto_en = ($urandom_range(7) != 0);
      we = ($urandom_range(3) != 0);
      din = 1'($urandom);
      sel = 3'($urandom);
      tick();
      total++;
      if (out8 !== 8'(m_out[0]) || ptr8 !== 3'(m_pos[0]) || done8 !== m_done[0]) begin
        bad++;
        $display("FAIL rand8 cyc%0d got out=%h ptr=%0d done=%b want out=%h ptr=%0d done=%b",
                 k, out8, ptr8, done8, 8'(m_out[0]), m_pos[0], m_done[0]);
      end
      total++;
      if (out6 !== 6'(m_out[1]) || ptr6 !== 3'(m_pos[1]) || done6 !== m_done[1]) begin
        bad++;
        $display("FAIL rand6 cyc%0d got out=%h ptr=%0d done=%b want out=%h ptr=%0d done=%b",
                 k, out6, ptr6, done6, 6'(m_out[1]), m_pos[1], m_done[1]);
      end
    end
    rst = 1'b0; we = 1'b0; auto_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_sh[i] = 0; m_pos[i] = 0; m_done[i] = 1'b0;
    end
    test_reset();
    test_manual();
    test_auto_frame(1'b0);
    test_auto_frame(1'b1);
    test_abort();
    test_size6();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
